// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared constants, FSM states and address field helpers for the instruction cache
package icache_pkg;

    localparam int NUM_BLOCKS  = 8;
    localparam int INDEX_W     = $clog2(NUM_BLOCKS);
    localparam int BLOCK_WORDS = 4;
    localparam int TAG_W       = 28 - INDEX_W;
    localparam int BLOCK_W     = 128;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_READ = 2'd1,
        S_UPDATE   = 2'd2
    } state_t;

    function automatic logic [TAG_W-1:0] get_tag(input logic [31:0] addr);
        return addr[31:4+INDEX_W];
    endfunction

    function automatic logic [INDEX_W-1:0] get_index(input logic [31:0] addr);
        return addr[4+INDEX_W-1:4];
    endfunction

    function automatic logic [1:0] get_offset(input logic [31:0] addr);
        return addr[3:2];
    endfunction

    // Same fields, taken from a 28-bit block address (ADDRESS[31:4]).
    function automatic logic [TAG_W-1:0] blk_tag(input logic [27:0] blk);
        return blk[27:INDEX_W];
    endfunction

    function automatic logic [INDEX_W-1:0] blk_index(input logic [27:0] blk);
        return blk[INDEX_W-1:0];
    endfunction

endpackage

// File: rtl/instruction_cache_if.sv
// rtl/instruction_cache_if.sv - refill port between the instruction cache and instruction memory
interface instruction_cache_if;

    logic                         MEM_READ;
    logic [27:0]                  MEM_ADDRESS;
    logic [icache_pkg::BLOCK_W-1:0] MEM_READDATA;
    logic                         MEM_BUSYWAIT;

    modport master (
        output MEM_READ,
        output MEM_ADDRESS,
        input  MEM_READDATA,
        input  MEM_BUSYWAIT
    );

    modport slave (
        input  MEM_READ,
        input  MEM_ADDRESS,
        output MEM_READDATA,
        output MEM_BUSYWAIT
    );

endinterface

// File: rtl/icache_storage.sv
// rtl/icache_storage.sv - valid/tag/data arrays with synchronous write, asynchronous hit lookup and word select
module icache_storage
    import icache_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [TAG_W-1:0]    rd_tag,
    input  logic [1:0]          rd_offset,
    output logic                hit,
    output logic [31:0]         rd_word,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [BLOCK_W-1:0]  wr_data
);

    logic [NUM_BLOCKS-1:0]              valid;
    logic [TAG_W-1:0]                   tags [NUM_BLOCKS];
    logic [BLOCK_WORDS-1:0][31:0]       data [NUM_BLOCKS];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data need no reset; an invalid line never produces a hit.
    always_ff @(posedge CLK) begin
        if (wr_en && !RESET) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_data;
        end
    end

    assign hit     = valid[rd_index] && (tags[rd_index] == rd_tag);
    assign rd_word = data[rd_index][rd_offset];

endmodule

// File: rtl/instruction_cache.sv
// rtl/instruction_cache.sv - direct-mapped read-only instruction cache with block refill FSM
module instruction_cache
    import icache_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          ADDRESS,
    output logic [31:0]          INSTRUCTION,
    output logic                 BUSYWAIT,
    instruction_cache_if.master  mem
);

    state_t               state, state_next;
    logic [27:0]          miss_addr, miss_addr_next;
    logic [BLOCK_W-1:0]   fill_buf, fill_buf_next;
    logic                 hit;
    logic [31:0]          hit_word;
    logic                 wr_en;
    logic                 mem_read;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^ADDRESS[1:0];

    icache_storage u_storage (
        .CLK       (CLK),
        .RESET     (RESET),
        .rd_index  (get_index(ADDRESS)),
        .rd_tag    (get_tag(ADDRESS)),
        .rd_offset (get_offset(ADDRESS)),
        .hit       (hit),
        .rd_word   (hit_word),
        .wr_en     (wr_en),
        .wr_index  (blk_index(miss_addr)),
        .wr_tag    (blk_tag(miss_addr)),
        .wr_data   (fill_buf)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            miss_addr <= '0;
        end else begin
            state     <= state_next;
            miss_addr <= miss_addr_next;
        end
        fill_buf <= fill_buf_next;
    end

    always_comb begin
        state_next     = state;
        miss_addr_next = miss_addr;
        fill_buf_next  = fill_buf;
        INSTRUCTION    = NOP;
        BUSYWAIT       = 1'b0;
        mem_read       = 1'b0;
        wr_en          = 1'b0;
        case (state)
            S_IDLE: begin
                if (hit) begin
                    INSTRUCTION = hit_word;
                end else begin
                    BUSYWAIT       = 1'b1;
                    state_next     = S_MEM_READ;
                    miss_addr_next = ADDRESS[31:4];
                end
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                BUSYWAIT = 1'b1;
                if (!mem.MEM_BUSYWAIT) begin
                    fill_buf_next = mem.MEM_READDATA;
                    state_next    = S_UPDATE;
                end
            end
            S_UPDATE: begin
                BUSYWAIT   = 1'b1;
                wr_en      = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // Reset overrides everything so a held PC never starts or finishes a refill.
        if (RESET) begin
            INSTRUCTION = NOP;
            BUSYWAIT    = 1'b0;
            mem_read    = 1'b0;
            wr_en       = 1'b0;
        end
    end

    assign mem.MEM_READ    = mem_read;
    assign mem.MEM_ADDRESS = miss_addr;

endmodule

// File: tb/tb_instruction_cache.sv
// tb/tb_instruction_cache.sv - directed self-checking bench for instruction_cache
module tb_instruction_cache;
    import icache_pkg::*;

    localparam int MEM_LAT = 5;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] ADDRESS;
    logic [31:0] INSTRUCTION;
    logic        BUSYWAIT;
    logic        idle_low;
    int          lat_cnt = 0;
    int          passed  = 0;
    int          total   = 0;

    logic [31:0] hit_addr [3];
    logic [31:0] hit_exp  [3];

    instruction_cache_if mem_if ();

    instruction_cache dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .ADDRESS     (ADDRESS),
        .INSTRUCTION (INSTRUCTION),
        .BUSYWAIT    (BUSYWAIT),
        .mem         (mem_if.master)
    );

    always #5 CLK = ~CLK;

    // Word k of block b holds (b*16 + k + 1).
    function automatic logic [127:0] block_of(input logic [27:0] ba);
        logic [31:0] base;
        base = {ba, 4'h0};
        return {base + 32'd4, base + 32'd3, base + 32'd2, base + 32'd1};
    endfunction

    assign mem_if.MEM_READDATA = idle_low ? {4{32'hDEADBEEF}} : block_of(mem_if.MEM_ADDRESS);
    assign mem_if.MEM_BUSYWAIT = idle_low ? 1'b0 :
                                 (mem_if.MEM_READ ? (lat_cnt < MEM_LAT) : 1'b1);

    always @(posedge CLK) lat_cnt <= mem_if.MEM_READ ? lat_cnt + 1 : 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic wait_refill(input string tag);
        int n;
        n = 0;
        while (BUSYWAIT !== 1'b0 && n < 40) begin
            @(negedge CLK); #1;
            n++;
        end
        check(tag, {31'b0, BUSYWAIT}, 32'd0);
    endtask

    initial begin
        hit_addr = '{32'h4, 32'h8, 32'hC};
        hit_exp  = '{32'h2, 32'h3, 32'h4};
        RESET    = 1'b1;
        ADDRESS  = 32'hFFFFFFFC;
        idle_low = 1'b0;

        repeat (2) @(negedge CLK);
        #1;
        check("rst_busywait", {31'b0, BUSYWAIT}, 32'd0);
        check("rst_mem_read", {31'b0, mem_if.MEM_READ}, 32'd0);
        check("rst_instr", INSTRUCTION, 32'h00000013);
        check("rst_mem_addr", {4'b0, mem_if.MEM_ADDRESS}, 32'd0);
        check("rst_valid", {24'b0, dut.u_storage.valid}, 32'd0);
        check("rst_state", {30'b0, dut.state}, {30'b0, S_IDLE});

        @(negedge CLK); RESET = 1'b0; ADDRESS = 32'h0; #1;
        check("cold_busywait", {31'b0, BUSYWAIT}, 32'd1);
        check("cold_instr", INSTRUCTION, 32'h00000013);
        check("cold_mem_read_idle", {31'b0, mem_if.MEM_READ}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK); #1;
            check("cold_mem_read", {31'b0, mem_if.MEM_READ}, 32'd1);
            check("cold_mem_addr", {4'b0, mem_if.MEM_ADDRESS}, 32'd0);
            check("cold_busy", {31'b0, BUSYWAIT}, 32'd1);
        end
        @(negedge CLK); #1;
        check("cold_update_mem_read", {31'b0, mem_if.MEM_READ}, 32'd0);
        check("cold_update_busy", {31'b0, BUSYWAIT}, 32'd1);
        check("cold_update_state", {30'b0, dut.state}, {30'b0, S_UPDATE});
        @(negedge CLK); #1;
        check("cold_hit_busy", {31'b0, BUSYWAIT}, 32'd0);
        check("cold_hit_instr", INSTRUCTION, 32'h1);

        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); ADDRESS = hit_addr[i]; #1;
            check("seq_instr", INSTRUCTION, hit_exp[i]);
            check("seq_busy", {31'b0, BUSYWAIT}, 32'd0);
            check("seq_mem_read", {31'b0, mem_if.MEM_READ}, 32'd0);
        end

        @(negedge CLK); ADDRESS = 32'h80; #1;
        check("conf_busy", {31'b0, BUSYWAIT}, 32'd1);
        check("conf_instr_nop", INSTRUCTION, 32'h00000013);
        @(negedge CLK); #1;
        check("conf_mem_read", {31'b0, mem_if.MEM_READ}, 32'd1);
        check("conf_mem_addr", {4'b0, mem_if.MEM_ADDRESS}, 32'h8);
        wait_refill("conf_refill_done");
        check("conf_instr", INSTRUCTION, 32'h81);
        @(negedge CLK); ADDRESS = 32'h8C; #1;
        check("conf_instr_w3", INSTRUCTION, 32'h84);

        @(negedge CLK); ADDRESS = 32'h0; #1;
        check("reuse_busy", {31'b0, BUSYWAIT}, 32'd1);
        @(negedge CLK); #1;
        check("reuse_mem_read", {31'b0, mem_if.MEM_READ}, 32'd1);
        check("reuse_mem_addr", {4'b0, mem_if.MEM_ADDRESS}, 32'd0);
        wait_refill("reuse_refill_done");
        check("reuse_instr", INSTRUCTION, 32'h1);

        @(negedge CLK); ADDRESS = 32'h10; #1;
        check("rr_busy", {31'b0, BUSYWAIT}, 32'd1);
        @(negedge CLK);
        @(negedge CLK); #1;
        check("rr_mem_read_c2", {31'b0, mem_if.MEM_READ}, 32'd1);
        @(negedge CLK); RESET = 1'b1; #1;
        check("rr_rst_busy", {31'b0, BUSYWAIT}, 32'd0);
        check("rr_rst_instr", INSTRUCTION, 32'h00000013);
        @(negedge CLK); RESET = 1'b0; #1;
        check("rr_state", {30'b0, dut.state}, {30'b0, S_IDLE});
        check("rr_mem_read", {31'b0, mem_if.MEM_READ}, 32'd0);
        check("rr_valid1", {31'b0, dut.u_storage.valid[1]}, 32'd0);
        check("rr_miss_busy", {31'b0, BUSYWAIT}, 32'd1);
        @(negedge CLK); #1;
        check("rr_mem_addr", {4'b0, mem_if.MEM_ADDRESS}, 32'h1);
        wait_refill("rr_refill_done");
        check("rr_instr", INSTRUCTION, 32'h11);

        @(negedge CLK); idle_low = 1'b1; #1;
        check("ip_busy", {31'b0, BUSYWAIT}, 32'd0);
        check("ip_mem_read", {31'b0, mem_if.MEM_READ}, 32'd0);
        check("ip_instr", INSTRUCTION, 32'h11);
        @(negedge CLK); idle_low = 1'b0; #1;
        check("ip_state", {30'b0, dut.state}, {30'b0, S_IDLE});
        check("ip_valid", {24'b0, dut.u_storage.valid}, 32'h02);
        check("ip_instr_after", INSTRUCTION, 32'h11);
        @(negedge CLK); ADDRESS = 32'h1C; #1;
        check("ip_instr_w3", INSTRUCTION, 32'h14);
        check("ip_final_busy", {31'b0, BUSYWAIT}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
